// File: rtl/adc_capture_pkg.sv
// Shared trigger-mode constants, state encoding and the edge-decision helper
// for the ADC triggered capture controller.
package adc_capture_pkg;

  localparam logic [1:0] TRIG_IMMEDIATE = 2'd0;
  localparam logic [1:0] TRIG_RISING    = 2'd1;
  localparam logic [1:0] TRIG_FALLING   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2
  } cap_state_t;

  // Reserved mode 3 falls into the default arm and behaves as immediate.
  function automatic logic edge_hit(
    input logic [1:0] mode,
    input logic       prev_valid,
    input logic       prev_below,
    input logic       cur_below
  );
    case (mode)
      TRIG_RISING:  edge_hit = prev_valid & prev_below & ~cur_below;
      TRIG_FALLING: edge_hit = prev_valid & ~prev_below & cur_below;
      default:      edge_hit = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/adc_capture_ctrl_trig_detect.sv
// Channel-1 level trigger: keeps the previous valid sample and flags the
// sample cycle on which the selected crossing of the signed threshold occurs.
module adc_trig_detect
  import adc_capture_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clr,
  input  logic                     i_en,
  input  logic                     i_valid,
  input  logic [1:0]               i_mode,
  input  logic signed [DATA_W-1:0] i_level,
  input  logic signed [DATA_W-1:0] i_cur,
  output logic                     o_trig_hit
);

  logic signed [DATA_W-1:0] r_prev;
  logic                     r_prev_valid;
  logic                     w_prev_below;
  logic                     w_cur_below;

  // Previous-sample history; only sample cycles while enabled advance it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev       <= {DATA_W{1'b0}};
      r_prev_valid <= 1'b0;
    end else if (i_clr) begin
      r_prev       <= {DATA_W{1'b0}};
      r_prev_valid <= 1'b0;
    end else if (i_en && i_valid) begin
      r_prev       <= i_cur;
      r_prev_valid <= 1'b1;
    end
  end

  // Signed threshold compare and mode-dependent edge decision.
  always_comb begin
    w_prev_below = (r_prev < i_level);
    w_cur_below  = (i_cur < i_level);
    o_trig_hit   = i_en & i_valid &
                   edge_hit(i_mode, r_prev_valid, w_prev_below, w_cur_below);
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Triggered capture controller: arms on request, waits for a channel-1 trigger,
// then writes capture_len decimated {ch1, ch2} slots to the sample FIFO.
module adc_capture_ctrl
  import adc_capture_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int CNT_W   = 24,
  parameter int DECIM_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_async,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [1:0]            trig_mode,
  input  logic [DATA_W-1:0]     trig_level,
  input  logic [CNT_W-1:0]      capture_len,
  input  logic [DECIM_W-1:0]    decim,
  input  logic [DATA_W-1:0]     adc_data_1,
  input  logic [DATA_W-1:0]     adc_data_2,
  input  logic                  data_valid,
  input  logic                  fifo_prog_full,
  output logic                  fifo_wr_en,
  output logic [2*DATA_W-1:0]   fifo_din,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [CNT_W-1:0]      sample_count
);

  localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [DECIM_W-1:0] DEC_ZERO = {DECIM_W{1'b0}};
  localparam logic [DECIM_W-1:0] DEC_ONE  = {{(DECIM_W-1){1'b0}}, 1'b1};

  cap_state_t               r_state;
  logic [1:0]               r_mode;
  logic signed [DATA_W-1:0] r_level;
  logic [CNT_W-1:0]         r_len;
  logic [DECIM_W-1:0]       r_decim;
  logic [CNT_W-1:0]         r_slot_cnt;
  logic [DECIM_W-1:0]       r_dec_cnt;
  logic [CNT_W-1:0]         r_sample_count;
  logic [2*DATA_W-1:0]      r_din;
  logic                     r_wr_en;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_overflow;

  logic                     w_trig_hit;
  logic                     w_arm_accept;
  logic                     w_armed;
  logic [CNT_W-1:0]         w_slot_next;
  logic                     w_last;
  logic                     w_dec_hit;
  logic                     w_keep;

  // Slot bookkeeping: which sample cycles consume a slot and which slot is last.
  always_comb begin
    w_arm_accept = arm & ~abort & (r_state == ST_IDLE);
    w_armed      = (r_state == ST_ARMED);
    w_slot_next  = r_slot_cnt + CNT_ONE;
    w_last       = (w_slot_next == r_len);
    w_dec_hit    = (r_dec_cnt == r_decim);
    w_keep       = ~abort &
                   ((w_armed & w_trig_hit & (r_len != CNT_ZERO)) |
                    ((r_state == ST_CAPTURE) & data_valid & w_dec_hit));
  end

  adc_trig_detect #(
    .DATA_W (DATA_W)
  ) u_trig (
    .clk        (clk),
    .rst        (reset_async),
    .i_clr      (w_arm_accept),
    .i_en       (w_armed),
    .i_valid    (data_valid),
    .i_mode     (r_mode),
    .i_level    (r_level),
    .i_cur      ($signed(adc_data_1)),
    .o_trig_hit (w_trig_hit)
  );

  // Capture FSM with registered FIFO strobe, data and status outputs.
  always_ff @(posedge clk or posedge reset_async) begin
    if (reset_async) begin
      r_state        <= ST_IDLE;
      r_mode         <= TRIG_IMMEDIATE;
      r_level        <= {DATA_W{1'b0}};
      r_len          <= CNT_ZERO;
      r_decim        <= DEC_ZERO;
      r_slot_cnt     <= CNT_ZERO;
      r_dec_cnt      <= DEC_ZERO;
      r_sample_count <= CNT_ZERO;
      r_din          <= {(2*DATA_W){1'b0}};
      r_wr_en        <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      if (abort) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (arm) begin
              r_mode         <= trig_mode;
              r_level        <= $signed(trig_level);
              r_len          <= capture_len;
              r_decim        <= decim;
              r_slot_cnt     <= CNT_ZERO;
              r_dec_cnt      <= DEC_ZERO;
              r_sample_count <= CNT_ZERO;
              r_done         <= 1'b0;
              r_overflow     <= 1'b0;
              r_state        <= ST_ARMED;
              r_busy         <= 1'b1;
            end
          end
          ST_ARMED: begin
            if (w_trig_hit) begin
              r_dec_cnt <= DEC_ZERO;
              // A zero-length capture finishes on the trigger itself.
              if ((r_len == CNT_ZERO) || w_last) begin
                r_done  <= 1'b1;
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_state <= ST_CAPTURE;
              end
            end
          end
          ST_CAPTURE: begin
            if (data_valid) begin
              r_dec_cnt <= w_dec_hit ? DEC_ZERO : (r_dec_cnt + DEC_ONE);
              if (w_dec_hit && w_last) begin
                r_done  <= 1'b1;
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase

        // A kept slot always counts; prog_full turns it into a drop.
        if (w_keep) begin
          r_slot_cnt <= w_slot_next;
          if (fifo_prog_full) begin
            r_overflow <= 1'b1;
          end else begin
            r_wr_en        <= 1'b1;
            r_din          <= {adc_data_1, adc_data_2};
            r_sample_count <= r_sample_count + CNT_ONE;
          end
        end
      end
    end
  end

  assign fifo_wr_en   = r_wr_en;
  assign fifo_din     = r_din;
  assign busy         = r_busy;
  assign done         = r_done;
  assign overflow     = r_overflow;
  assign sample_count = r_sample_count;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Self-checking bench for adc_capture_ctrl: directed and randomized capture
// streams compared against a slot-list reference model.
module tb_adc_capture_ctrl;

  localparam int DATA_W  = 16;
  localparam int CNT_W   = 24;
  localparam int DECIM_W = 8;
  localparam int N       = 64;

  logic                clk = 1'b0;
  logic                reset_async;
  logic                arm, abort;
  logic [1:0]          trig_mode;
  logic [DATA_W-1:0]   trig_level;
  logic [CNT_W-1:0]    capture_len;
  logic [DECIM_W-1:0]  decim;
  logic [DATA_W-1:0]   adc_data_1, adc_data_2;
  logic                data_valid, fifo_prog_full;
  logic                fifo_wr_en;
  logic [2*DATA_W-1:0] fifo_din;
  logic                busy, done, overflow;
  logic [CNT_W-1:0]    sample_count;

  adc_capture_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W), .DECIM_W(DECIM_W)) dut (
    .clk(clk), .reset_async(reset_async), .arm(arm), .abort(abort),
    .trig_mode(trig_mode), .trig_level(trig_level), .capture_len(capture_len),
    .decim(decim), .adc_data_1(adc_data_1), .adc_data_2(adc_data_2),
    .data_valid(data_valid), .fifo_prog_full(fifo_prog_full),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .busy(busy), .done(done),
    .overflow(overflow), .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [DATA_W-1:0]   s_ch1 [N];
  logic [DATA_W-1:0]   s_ch2 [N];
  logic                s_dv  [N];
  logic                s_pf  [N];

  int                  got_idx[$];
  logic [2*DATA_W-1:0] got_din[$];
  int                  exp_idx[$];
  logic [2*DATA_W-1:0] exp_din[$];
  logic                e_done, e_ov, e_busy;
  int                  e_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_arm(input int mode, input int level, input int len, input int dcm);
    trig_mode   = 2'(mode);
    trig_level  = 16'(level);
    capture_len = 24'(len);
    decim       = 8'(dcm);
    arm = 1'b1; data_valid = 1'b0; fifo_prog_full = 1'b0;
    @(posedge clk); #1;
    arm = 1'b0;
    trig_mode   = 2'($urandom);
    trig_level  = 16'($urandom);
    capture_len = 24'($urandom);
    decim       = 8'($urandom);
  endtask

  task automatic pulse_abort();
    abort = 1'b1; data_valid = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0;
  endtask

  task automatic run_stream(input int n);
    got_idx.delete(); got_din.delete();
    for (int i = 0; i < n; i++) begin
      adc_data_1 = s_ch1[i]; adc_data_2 = s_ch2[i];
      data_valid = s_dv[i];  fifo_prog_full = s_pf[i];
      @(posedge clk); #1;
      if (fifo_wr_en === 1'b1) begin
        got_idx.push_back(i);
        got_din.push_back(fifo_din);
      end
    end
    data_valid = 1'b0; fifo_prog_full = 1'b0;
  endtask

  // Reference: locate the trigger among sample cycles, then list kept slots.
  task automatic model(input int mode, input int level, input int len, input int dcm, input int n);
    int sidx[$];
    int k, a, b, t2, c;
    exp_idx.delete(); exp_din.delete();
    e_done = 1'b0; e_ov = 1'b0; e_busy = 1'b1; e_cnt = 0;
    for (int i = 0; i < n; i++) if (s_dv[i]) sidx.push_back(i);
    k = -1;
    for (int t = 0; t < sidx.size() && k < 0; t++) begin
      if (mode == 1 || mode == 2) begin
        if (t > 0) begin
          a = int'($signed(s_ch1[sidx[t-1]]));
          b = int'($signed(s_ch1[sidx[t]]));
          if (mode == 1 && a < level && b >= level) k = t;
          if (mode == 2 && a >= level && b < level) k = t;
        end
      end else begin
        k = t;
      end
    end
    if (k >= 0) begin
      if (len == 0) begin
        e_done = 1'b1; e_busy = 1'b0;
      end
      for (int j = 0; j < len; j++) begin
        t2 = k + j * (dcm + 1);
        if (t2 >= sidx.size()) break;
        c = sidx[t2];
        if (s_pf[c]) e_ov = 1'b1;
        else begin
          exp_idx.push_back(c);
          exp_din.push_back({s_ch1[c], s_ch2[c]});
          e_cnt++;
        end
        if (j == len - 1) begin
          e_done = 1'b1; e_busy = 1'b0;
        end
      end
    end
  endtask

  task automatic compare(input string tag);
    check($sformatf("%s_nwr", tag), 64'(got_idx.size()), 64'(exp_idx.size()));
    for (int i = 0; i < exp_idx.size() && i < got_idx.size(); i++) begin
      check($sformatf("%s_wcyc%0d", tag, i), 64'(got_idx[i]), 64'(exp_idx[i]));
      check($sformatf("%s_wdat%0d", tag, i), 64'(got_din[i]), 64'(exp_din[i]));
    end
    check($sformatf("%s_done", tag), 64'(done), 64'(e_done));
    check($sformatf("%s_ovf", tag), 64'(overflow), 64'(e_ov));
    check($sformatf("%s_cnt", tag), 64'(sample_count), 64'(e_cnt));
    check($sformatf("%s_busy", tag), 64'(busy), 64'(e_busy));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr"},   64'(fifo_wr_en), 64'd0);
    check({tag, "_din"},  64'(fifo_din), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_ovf"},  64'(overflow), 64'd0);
    check({tag, "_cnt"},  64'(sample_count), 64'd0);
  endtask

  task automatic fill_default(input int n);
    for (int i = 0; i < n; i++) begin
      s_ch1[i] = 16'($urandom); s_ch2[i] = 16'($urandom);
      s_dv[i] = 1'b1; s_pf[i] = 1'b0;
    end
  endtask

  initial begin
    int v, mode, level, len, dcm;
    reset_async = 1'b1; arm = 1'b0; abort = 1'b0;
    trig_mode = 2'd0; trig_level = 16'd0; capture_len = 24'd0; decim = 8'd0;
    adc_data_1 = 16'd0; adc_data_2 = 16'd0; data_valid = 1'b0; fifo_prog_full = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("rst");
    @(negedge clk); reset_async = 1'b0;
    @(posedge clk); #1;

    // Immediate ramp.
    fill_default(10);
    for (int i = 0; i < 10; i++) s_ch1[i] = 16'(i);
    do_arm(0, 0, 4, 0); run_stream(10); model(0, 0, 4, 0, 10); compare("imm");

    // Rising edge through level 100, then a ramp that starts above it.
    fill_default(10);
    for (int i = 0; i < 10; i++) begin
      v = (i == 0) ? 50 : (i == 1) ? 90 : (i == 2) ? 99 : (i == 3) ? 100 : 116 + i;
      s_ch1[i] = 16'(v); s_ch2[i] = 16'(v + 1000);
    end
    do_arm(1, 100, 3, 0); run_stream(10); model(1, 100, 3, 0, 10); compare("rise");
    check("rise_first", 64'((got_din.size() > 0) ? got_din[0] : 32'hxxxxxxxx),
          64'({16'd100, 16'd1100}));
    for (int i = 0; i < 10; i++) begin s_ch1[i] = 16'(150 + i); s_ch2[i] = 16'(i); end
    do_arm(1, 100, 3, 0); run_stream(10); model(1, 100, 3, 0, 10); compare("rise_none");
    pulse_abort();

    // Falling edge with decimation and gaps in data_valid.
    fill_default(30);
    v = 0;
    for (int i = 0; i < 30; i++) begin
      s_dv[i] = (i % 3 != 2);
      if (s_dv[i]) begin
        s_ch1[i] = 16'(v);
        v = (v == 0) ? -5 : (v == -5) ? -20 : v - 1;
      end
    end
    do_arm(2, -10, 3, 2); run_stream(30); model(2, -10, 3, 2, 30); compare("fall");
    check("fall_first", 64'((got_din.size() > 0) ? got_din[0][31:16] : 16'hxxxx),
          64'(16'hFFEC));

    // Backpressure on slots 3 and 4.
    fill_default(10);
    s_pf[3] = 1'b1; s_pf[4] = 1'b1;
    do_arm(0, 0, 8, 0); run_stream(10); model(0, 0, 8, 0, 10); compare("bp");
    check("bp_cnt6", 64'(sample_count), 64'd6);

    // Fresh arm clears sticky status; abort after two writes.
    fill_default(2);
    do_arm(0, 0, 10, 0);
    check("arm_clr_ovf", 64'(overflow), 64'd0);
    check("arm_clr_done", 64'(done), 64'd0);
    run_stream(2); model(0, 0, 10, 0, 2); compare("pre_abort");
    abort = 1'b1; data_valid = 1'b1; adc_data_1 = 16'h1234;
    @(posedge clk); #1;
    abort = 1'b0; data_valid = 1'b0;
    check("abort_wr", 64'(fifo_wr_en), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_cnt", 64'(sample_count), 64'd2);

    // Arm while ARMED is ignored.
    do_arm(1, 30000, 2, 0);
    trig_mode = 2'd0; capture_len = 24'd5; arm = 1'b1;
    adc_data_1 = 16'd0; data_valid = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
    check("rearm_wr", 64'(fifo_wr_en), 64'd0);
    fill_default(6);
    for (int i = 0; i < 6; i++) s_ch1[i] = 16'(i);
    run_stream(6);
    check("rearm_nwr", 64'(got_idx.size()), 64'd0);
    check("rearm_busy", 64'(busy), 64'd1);
    pulse_abort();

    // Zero-length capture.
    fill_default(3);
    do_arm(0, 0, 0, 0); run_stream(3); model(0, 0, 0, 0, 3); compare("len0");

    // Asynchronous reset during a capture.
    fill_default(3);
    do_arm(0, 0, 20, 0); run_stream(3);
    check("rst_mid_pre", 64'(got_idx.size()), 64'd3);
    data_valid = 1'b1; adc_data_1 = 16'h0077;
    @(posedge clk); #2;
    reset_async = 1'b1; #1;
    check_all_zero("rst_mid");
    #1 reset_async = 1'b0;
    @(posedge clk); #1;
    fill_default(4); run_stream(4);
    check("rst_mid_nwr", 64'(got_idx.size()), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);

    // Randomized captures.
    for (int r = 0; r < 10; r++) begin
      mode  = $urandom_range(0, 3);
      level = $urandom_range(0, 400) - 200;
      len   = $urandom_range(0, 6);
      dcm   = $urandom_range(0, 3);
      for (int i = 0; i < 40; i++) begin
        s_ch1[i] = 16'(level + $urandom_range(0, 60) - 30);
        s_ch2[i] = 16'($urandom);
        s_dv[i]  = ($urandom_range(0, 3) != 0);
        s_pf[i]  = ($urandom_range(0, 4) == 0);
      end
      do_arm(mode, level, len, dcm); run_stream(40); model(mode, level, len, dcm, 40);
      compare($sformatf("rnd%0d", r));
      pulse_abort();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
